// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx : byte-oriented 8N1 UART transmitter driving the SoC serial pin.
//
// Bytes written by the CPU are buffered and serialised as:
//   start bit (0), data d0..d7 LSB first, stop bit (1), no parity.
// Each bit lasts exactly CLK_DIV clock cycles. Back-to-back frames are sent
// with no idle gap: the next start bit begins on the edge that ends the
// previous stop bit.
//
// Build option:
//   UART_TX_FIFO_EN  defined   -> circular buffer of FIFO_DEPTH entries
//                    undefined -> single holding register (FIFO_DEPTH ignored)
//
// Parameters:
//   CLK_DIV    : clock cycles per bit, >= 2
//   FIFO_DEPTH : buffer entries when UART_TX_FIFO_EN is defined, power of 2, >= 2
//
// Ports:
//   CLK     in  : system clock, all state on rising edge
//   RESET   in  : asynchronous active-high reset; aborts any frame in flight
//   wr_en   in  : write strobe, byte accepted on an edge where wr_en && ready
//   wr_data in  : byte to send
//   ready   out : buffer not full (combinational from registered state)
//   busy    out : FSM not idle or buffer not empty
//   tx      out : registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BAUD_ZERO = CNT_W'(0);

    // Reject illegal parameter combinations at elaboration time.
    if ((CLK_DIV < 2) || (FIFO_DEPTH < 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_err
        $error("uart_tx: CLK_DIV must be >= 2, FIFO_DEPTH a power of two >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Buffer view shared by both buffer flavours.
    logic       push_s;      // accepted write this cycle
    logic       pop_s;       // FSM takes the head byte this cycle
    logic       buf_empty_s;
    logic       buf_full_s;
    logic [7:0] buf_head_s;  // byte that a pop would return

    assign push_s = wr_en && !buf_full_s;

`ifdef UART_TX_FIFO_EN
    // ------------------------------------------------------------------
    // Circular FIFO: read/write pointers plus an occupancy count. The count
    // is one bit wider than the pointers so that "full" is unambiguous.
    // ------------------------------------------------------------------
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    assign buf_empty_s = (count_q == CNT_ZERO);
    assign buf_full_s  = (count_q == CNT_FULL);
    assign buf_head_s  = fifo_mem[rd_ptr_q];

    // Storage array: written on accepted writes only, needs no reset
    // because the count decides which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end else begin
            fifo_mem[wr_ptr_q] <= fifo_mem[wr_ptr_q];
        end
    end

    // Pointer and count update; a simultaneous push and pop keeps the count.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    // ------------------------------------------------------------------
    // Single holding register. It is emptied when the FSM pops it at frame
    // start, so one further byte can be queued while a frame is on the wire.
    // A push and a pop can never coincide: push needs the register empty,
    // pop needs it full.
    // ------------------------------------------------------------------
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;

    assign buf_empty_s = !hold_valid_q;
    assign buf_full_s  = hold_valid_q;
    assign buf_head_s  = hold_q;

    // Holding register load/empty decision.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (push_s) begin
            hold_d       = wr_data;
            hold_valid_d = 1'b1;
        end else if (pop_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Transmit FSM with baud counter, bit index and shift register.
    // ------------------------------------------------------------------
    state_e           state_q,   state_d;
    logic [CNT_W-1:0] baud_q,    baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             tx_q,      tx_d;
    logic             bit_end_s;

    // A bit period ends on the edge where the down-counter sits at zero.
    assign bit_end_s = (baud_q == BAUD_ZERO);

    // FSM state and datapath registers; reset returns the line high at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            baud_q    <= BAUD_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Next-state logic: bit timing, shifting and buffer pops.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!buf_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_START;
                    baud_d  = BAUD_LOAD;
                    shift_d = buf_head_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    baud_d    = BAUD_LOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d   = ST_STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    // Chain straight into the next start bit when a byte waits.
                    if (!buf_empty_s) begin
                        pop_s   = 1'b1;
                        state_d = ST_START;
                        baud_d  = BAUD_LOAD;
                        shift_d = buf_head_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = BAUD_ZERO;
            end
        endcase
    end

    // Output logic: the line level is computed for the state being entered
    // so that the registered tx changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx    = tx_q;
    assign ready = !buf_full_s;
    assign busy  = (state_q != ST_IDLE) || !buf_empty_s;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx : directed self-checking bench for uart_tx.
// Two instances: CLK_DIV=4 (main tests) and CLK_DIV=2 (divider minimum).
// Buffer-specific tests follow the UART_TX_FIFO_EN build option.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en4, wr_en2;
    logic [7:0] wr_data4, wr_data2;
    logic       ready4, busy4, tx4;
    logic       ready2, busy2, tx2;

    int total = 0;
    int bad   = 0;

    logic [7:0] b2b_seq [4];
    logic [7:0] ovf_seq [6];
    logic [7:0] rst_seq [3];

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut4 (
        .CLK(clk), .RESET(rst), .wr_en(wr_en4), .wr_data(wr_data4),
        .ready(ready4), .busy(busy4), .tx(tx4)
    );

    uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
        .CLK(clk), .RESET(rst), .wr_en(wr_en2), .wr_data(wr_data2),
        .ready(ready2), .busy(busy2), .tx(tx2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk one full frame starting at the next edge, checking tx every cycle.
    task automatic check_frame(input bit sel, input logic [7:0] b, input int div);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < div; j++) begin
                tick();
                check($sformatf("tx_d%0d_%02h_bit%0d_c%0d", div, b, k, j),
                      32'(sel ? tx2 : tx4), 32'(bits[k]));
            end
        end
    endtask

    // After the final stop bit: busy drops on the next edge, line stays idle.
    task automatic check_idle_after(input string tag, input int cycles);
        check({tag, "_busy_last"}, 32'(busy4), 32'd1);
        tick();
        check({tag, "_busy_fall"}, 32'(busy4), 32'd0);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({tag, "_idle_tx"}, 32'(tx4), 32'd1);
        end
        check({tag, "_idle_busy"}, 32'(busy4), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q;
        int qn;
        logic acc;

        b2b_seq = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
        ovf_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        rst_seq = '{8'hC3, 8'h5A, 8'h7E};

        rst = 1'b1;
        wr_en4 = 1'b0; wr_data4 = 8'h00;
        wr_en2 = 1'b0; wr_data2 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx4",    32'(tx4),    32'd1);
        check("rst_ready4", 32'(ready4), 32'd1);
        check("rst_busy4",  32'(busy4),  32'd0);
        check("rst_tx2",    32'(tx2),    32'd1);
        check("rst_busy2",  32'(busy2),  32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Single byte 0x55 with CLK_DIV=4.
        wr_en4 = 1'b1; wr_data4 = 8'h55;
        tick();
        wr_en4 = 1'b0;
        check("single_busy_n",  32'(busy4), 32'd1);
        check("single_tx_n",    32'(tx4),   32'd1);
        check_frame(1'b0, 8'h55, 4);
        check_idle_after("single", 4);

`ifdef UART_TX_FIFO_EN
        // Back-to-back: four writes on consecutive edges, four gapless frames.
        wr_en4 = 1'b1; wr_data4 = b2b_seq[0];
        tick();
        check("b2b_ready0", 32'(ready4), 32'd1);
        fork
            begin
                for (int i = 1; i < 4; i++) begin
                    wr_en4 = 1'b1; wr_data4 = b2b_seq[i];
                    tick();
                    check($sformatf("b2b_ready%0d", i), 32'(ready4), 32'd1);
                end
                wr_en4 = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) check_frame(1'b0, b2b_seq[i], 4);
            end
        join
        check_idle_after("b2b", 8);

        // Overflow: six writes while idle; the sixth is dropped.
        wr_en4 = 1'b1; wr_data4 = ovf_seq[0];
        tick();
        check("ovf_ready0", 32'(ready4), 32'd1);
        fork
            begin
                for (int i = 1; i < 6; i++) begin
                    wr_en4 = 1'b1; wr_data4 = ovf_seq[i];
                    tick();
                    check($sformatf("ovf_ready%0d", i), 32'(ready4),
                          (i < 4) ? 32'd1 : 32'd0);
                end
                wr_en4 = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) check_frame(1'b0, ovf_seq[i], 4);
            end
        join
        check_idle_after("ovf", 48);
        qn = 3;
`else
        // Holding register: 0x11, then 0x22 once the register frees, 0x33 dropped.
        wr_en4 = 1'b1; wr_data4 = 8'h11;
        tick();
        check("hold_ready_full", 32'(ready4), 32'd0);
        fork
            begin
                wr_en4 = 1'b1; wr_data4 = 8'h22;
                tick();
                check("hold_ready_freed", 32'(ready4), 32'd1);
                tick();
                check("hold_ready_22", 32'(ready4), 32'd0);
                wr_data4 = 8'h33;
                tick();
                check("hold_ready_33", 32'(ready4), 32'd0);
                wr_en4 = 1'b0;
            end
            begin
                check_frame(1'b0, 8'h11, 4);
                check_frame(1'b0, 8'h22, 4);
            end
        join
        check_idle_after("hold", 48);
        qn = 2;
`endif

        // Mid-frame reset during data bit 3 of 0xC3 with bytes queued behind it.
        q = 0;
        for (int e = 0; e < 20; e++) begin
            if (q < qn) begin
                wr_en4 = 1'b1; wr_data4 = rst_seq[q]; acc = ready4;
            end else begin
                wr_en4 = 1'b0; acc = 1'b0;
            end
            tick();
            if (acc) q++;
        end
        wr_en4 = 1'b0;
        check("mrst_queued",   32'(q),     32'(qn));
        check("mrst_busy_pre", 32'(busy4), 32'd1);
        check("mrst_tx_d3",    32'(tx4),   32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_tx",    32'(tx4),    32'd1);
        check("mrst_busy",  32'(busy4),  32'd0);
        check("mrst_ready", 32'(ready4), 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick();
            check("mrst_after_tx", 32'(tx4), 32'd1);
        end
        check("mrst_after_busy", 32'(busy4), 32'd0);

        // Divider minimum: CLK_DIV=2, byte 0x80.
        wr_en2 = 1'b1; wr_data2 = 8'h80;
        tick();
        wr_en2 = 1'b0;
        check("div2_busy_n", 32'(busy2), 32'd1);
        check_frame(1'b1, 8'h80, 2);
        check("div2_busy_last", 32'(busy2), 32'd1);
        tick();
        check("div2_busy_fall", 32'(busy2), 32'd0);
        check("div2_tx_idle",   32'(tx2),   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
